// File: rtl/scroll_pkg.sv
// scroll_pkg
// Shared definitions for the frame-synchronous scroll controller:
//   - state_t       : FSM state encoding (IDLE, RUN, PAUSE, HOME)
//   - OFFSET_W      : width of the vertical row offset
//   - speed_period  : maps the 2-bit speed code to a step period in frames
package scroll_pkg;

  localparam int OFFSET_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HOME  = 2'd3
  } state_t;

  // Speed code 0..3 selects a step every 1, 2, 4 or 8 frames.
  function automatic logic [3:0] speed_period(input logic [1:0] speed);
    return 4'd1 << speed;
  endfunction

endpackage

// File: rtl/frame_tick_div.sv
// frame_tick_div
// Divides frame_start pulses down to scroll step ticks.
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   clear       : holds the frame counter at zero and suppresses the tick
//   frame_start : one-cycle pulse per video frame
//   speed       : step period select (1, 2, 4, 8 frames), sampled per frame
//   step_tick   : combinational, high on the frame_start cycle that steps
module frame_tick_div
  import scroll_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       frame_start,
  input  logic [1:0] speed,
  output logic       step_tick
);

  logic [2:0] fcnt_q;
  logic [2:0] fcnt_d;
  logic       at_period;

  // The compare is >= rather than == so that lowering the speed while the
  // counter is already past the new period steps on the very next frame.
  always_comb begin
    at_period = ({1'b0, fcnt_q} >= (speed_period(speed) - 4'd1));
    step_tick = 1'b0;
    fcnt_d    = fcnt_q;
    if (clear) begin
      fcnt_d = 3'd0;
    end else if (frame_start) begin
      if (at_period) begin
        step_tick = 1'b1;
        fcnt_d    = 3'd0;
      end else begin
        fcnt_d = fcnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= 3'd0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl
// Frame-synchronous vertical scroll controller for the BRAM picture path.
// Offset changes only on frame_start cycles, so the picture never tears.
// Parameters:
//   IMG_H : picture height in rows (2..511)
//   STEP  : rows moved per step (1..IMG_H-1)
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   btn_pulse   : toggles run/pause (ignored in HOME)
//   dir_pulse   : toggles scroll direction in any state
//   home_pulse  : returns offset to 0 at the next frame and stops scrolling
//   frame_start : one-cycle pulse at start of vertical blanking
//   speed       : step period select (1, 2, 4, 8 frames)
//   v_offset    : current row offset, 0..IMG_H-1
//   running     : high while in RUN
//   dir         : 0 = offset increments, 1 = offset decrements
//   state       : current FSM state
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int IMG_H = 240,
  parameter int STEP  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_pulse,
  input  logic                dir_pulse,
  input  logic                home_pulse,
  input  logic                frame_start,
  input  logic [1:0]          speed,
  output logic [OFFSET_W-1:0] v_offset,
  output logic                running,
  output logic                dir,
  output logic [1:0]          state
);

  localparam logic [OFFSET_W:0] STEP_W  = (OFFSET_W+1)'(STEP);
  localparam logic [OFFSET_W:0] IMG_H_W = (OFFSET_W+1)'(IMG_H);

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] v_offset_q, v_offset_d;
  logic                dir_q, dir_d;
  logic                running_q, running_d;
  logic                div_clear;
  logic                step_tick;
  logic [OFFSET_W:0]   off_ext;
  logic [OFFSET_W:0]   off_up;
  logic [OFFSET_W:0]   off_dn;
  logic [OFFSET_W-1:0] off_next;

  // The divider only counts while RUN continues undisturbed; holding it clear
  // elsewhere also gives the required reset of fcnt on every entry to RUN,
  // and a coincident button or home pulse suppresses the step.
  assign div_clear = (state_q != RUN) | btn_pulse | home_pulse;

  frame_tick_div u_div (
    .clk         (clk),
    .rst         (rst),
    .clear       (div_clear),
    .frame_start (frame_start),
    .speed       (speed),
    .step_tick   (step_tick)
  );

  // Modular step with one extra bit so the sum never loses its carry.
  always_comb begin
    off_ext = {1'b0, v_offset_q};
    off_up  = off_ext + STEP_W;
    if (off_up >= IMG_H_W) begin
      off_up = off_up - IMG_H_W;
    end
    if (off_ext >= STEP_W) begin
      off_dn = off_ext - STEP_W;
    end else begin
      off_dn = off_ext + IMG_H_W - STEP_W;
    end
    off_next = dir_q ? off_dn[OFFSET_W-1:0] : off_up[OFFSET_W-1:0];
  end

  // Next-state logic; the step uses the pre-toggle direction held in dir_q.
  always_comb begin
    state_d    = state_q;
    v_offset_d = v_offset_q;
    dir_d      = dir_q ^ dir_pulse;
    unique case (state_q)
      IDLE: begin
        if (btn_pulse) state_d = RUN;
      end
      RUN: begin
        if (btn_pulse) begin
          state_d = PAUSE;
        end else if (step_tick) begin
          v_offset_d = off_next;
        end
      end
      PAUSE: begin
        if (btn_pulse) state_d = RUN;
      end
      HOME: begin
        if (frame_start) begin
          state_d    = IDLE;
          v_offset_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (home_pulse) begin
      state_d    = HOME;
      v_offset_d = v_offset_q;
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      v_offset_q <= '0;
      dir_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      v_offset_q <= v_offset_d;
      dir_q      <= dir_d;
      running_q  <= running_d;
    end
  end

  assign v_offset = v_offset_q;
  assign running  = running_q;
  assign dir      = dir_q;
  assign state    = state_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl
// Directed bench for scroll_ctrl. Two instances share all stimulus: one with
// STEP=1 and one with STEP=7, both with IMG_H=240. Expected values are
// hand-computed from the scroll rules.
module tb_scroll_ctrl;
  import scroll_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pulse = 1'b0;
  logic       dir_pulse = 1'b0;
  logic       home_pulse = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] speed = 2'd0;

  logic [8:0] v_offset, v_offset7;
  logic       running, running7;
  logic       dir, dir7;
  logic [1:0] state, state7;

  int vectors = 0;
  int miscompares = 0;

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  scroll_ctrl #(.IMG_H(240), .STEP(1)) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .dir_pulse(dir_pulse),
    .home_pulse(home_pulse), .frame_start(frame_start), .speed(speed),
    .v_offset(v_offset), .running(running), .dir(dir), .state(state)
  );

  scroll_ctrl #(.IMG_H(240), .STEP(7)) dut7 (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .dir_pulse(dir_pulse),
    .home_pulse(home_pulse), .frame_start(frame_start), .speed(speed),
    .v_offset(v_offset7), .running(running7), .dir(dir7), .state(state7)
  );

  // Single comparison point; X/Z on the observed side counts as a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of pulses, then leave the bench 1 time unit past the
  // sampling edge so registered outputs can be checked.
  task automatic applyStimulus(input logic b, input logic d, input logic h,
                               input logic f);
    @(negedge clk);
    btn_pulse   = b;
    dir_pulse   = d;
    home_pulse  = h;
    frame_start = f;
    @(posedge clk);
    #1;
    btn_pulse   = 1'b0;
    dir_pulse   = 1'b0;
    home_pulse  = 1'b0;
    frame_start = 1'b0;
  endtask

  // Back-to-back frame_start pulses on consecutive cycles.
  task automatic frames(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    doReset();
    checkOutput("rst_state", 32'(state), 32'(IDLE));
    checkOutput("rst_offset", 32'(v_offset), 0);
    checkOutput("rst_running", 32'(running), 0);
    checkOutput("rst_dir", 32'(dir), 0);
    checkOutput("rst_offset7", 32'(v_offset7), 0);

    // Start at speed 0, offset counts 1..5
    speed = 2'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_state", 32'(state), 32'(RUN));
    checkOutput("start_running", 32'(running), 1);
    for (int i = 1; i <= 5; i++) begin
      frames(1);
      checkOutput($sformatf("count_%0d", i), 32'(v_offset), 32'(i));
    end
    checkOutput("count7_35", 32'(v_offset7), 35);

    // STEP=7 wrap 236 -> 3 (68 steps reach 236)
    frames(63);
    checkOutput("pre_wrap1", 32'(v_offset), 68);
    checkOutput("pre_wrap7", 32'(v_offset7), 236);
    frames(1);
    checkOutput("wrap7_up", 32'(v_offset7), 3);
    checkOutput("step1_69", 32'(v_offset), 69);

    // Downward wrap from 0, dir toggle with coincident step, upward wrap 239->0
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("dir_set", 32'(dir), 1);
    frames(1);
    checkOutput("wrap_dn", 32'(v_offset), 239);
    checkOutput("wrap7_dn", 32'(v_offset7), 233);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("dir_step_old", 32'(v_offset), 238);
    checkOutput("dir7_step_old", 32'(v_offset7), 226);
    checkOutput("dir_clr", 32'(dir), 0);
    frames(1);
    checkOutput("up_239", 32'(v_offset), 239);
    frames(1);
    checkOutput("wrap_up", 32'(v_offset), 0);
    checkOutput("wrap7_up0", 32'(v_offset7), 0);

    // Speed 2: step on every 4th frame; then drop to speed 0 with fcnt=2
    doReset();
    speed = 2'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      frames(1);
      checkOutput($sformatf("spd2_f%0d", i), 32'(v_offset), 32'(i / 4));
    end
    checkOutput("spd2_off7", 32'(v_offset7), 21);
    frames(2);
    checkOutput("spd2_hold", 32'(v_offset), 3);
    speed = 2'd0;
    frames(1);
    checkOutput("spd_drop", 32'(v_offset), 4);

    // Pause coincident with frame_start at offset 10
    frames(6);
    checkOutput("pre_pause", 32'(v_offset), 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("pause_state", 32'(state), 32'(PAUSE));
    checkOutput("pause_off", 32'(v_offset), 10);
    checkOutput("pause_running", 32'(running), 0);
    frames(3);
    checkOutput("pause_hold", 32'(v_offset), 10);
    checkOutput("pause_hold7", 32'(v_offset7), 70);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_state", 32'(state), 32'(RUN));
    frames(1);
    checkOutput("resume_step", 32'(v_offset), 11);

    // Home with coincident button at offset 50
    frames(39);
    checkOutput("pre_home", 32'(v_offset), 50);
    checkOutput("pre_home7", 32'(v_offset7), 110);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("home_state", 32'(state), 32'(HOME));
    checkOutput("home_off", 32'(v_offset), 50);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("home_btn_ign", 32'(state), 32'(HOME));
    frames(1);
    checkOutput("home_done_off", 32'(v_offset), 0);
    checkOutput("home_done_state", 32'(state), 32'(IDLE));
    checkOutput("home_done_off7", 32'(v_offset7), 0);

    // Home coincident with frame_start keeps the offset for one frame
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    frames(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("homefs_state", 32'(state), 32'(HOME));
    checkOutput("homefs_off", 32'(v_offset), 3);
    frames(1);
    checkOutput("homefs_clear", 32'(v_offset), 0);

    // Async reset between edges at offset 120
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    frames(120);
    checkOutput("pre_arst", 32'(v_offset), 120);
    checkOutput("pre_arst7", 32'(v_offset7), 120);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_arst_dir", 32'(dir), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_off", 32'(v_offset), 0);
    checkOutput("arst_state", 32'(state), 32'(IDLE));
    checkOutput("arst_dir", 32'(dir), 0);
    checkOutput("arst_running", 32'(running), 0);
    checkOutput("arst_off7", 32'(v_offset7), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scroll_ctrl.md
# scroll_ctrl

Frame-synchronous scroll controller for the 320x240 BRAM picture path. It sequences the vertical scroll offset consumed by the address generator. Button pulses start, pause and resume scrolling; a separate pulse returns the picture home. Every offset change lands only at a frame boundary, so the VGA output never tears mid-frame.

## Interface
Parameters:
- IMG_H, 240, picture height in rows; legal range 2..511.
- STEP, 1, rows moved per scroll step; legal range 1..IMG_H-1.

Ports:
- clk  in  1  system clock. The VGA pixel clock domain supplies frame_start already synchronous to clk.
- rst  in  1  asynchronous, active-high reset.
- btn_pulse  in  1  one-cycle pulse, already debounced and one-pulsed. Toggles run/pause.
- dir_pulse  in  1  one-cycle pulse. Toggles scroll direction.
- home_pulse  in  1  one-cycle pulse. Returns the offset to 0 and stops scrolling.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- speed  in  2  step period in frames: 1, 2, 4 or 8 for speed = 0, 1, 2, 3.
- v_offset  out  9  current row offset, 0..IMG_H-1.
- running  out  1  high while in RUN.
- dir  out  1  0 = offset increments (picture moves up), 1 = offset decrements.
- state  out  2  current FSM state.

## Operation
FSM states:
- IDLE = 0
- RUN = 1
- PAUSE = 2
- HOME = 3

Transitions, evaluated on each clk edge:
- Any state, home_pulse → HOME. home_pulse has priority over btn_pulse in the same cycle.
- IDLE, btn_pulse → RUN.
- RUN, btn_pulse → PAUSE.
- PAUSE, btn_pulse → RUN.
- HOME, frame_start → IDLE, with v_offset ← 0. btn_pulse is ignored while in HOME.

Frame divider:
- 3-bit counter fcnt, cleared on every entry to RUN.
- In RUN, each frame_start evaluates fcnt ≥ (1<<speed)-1:
  - true: take a step and clear fcnt;
  - false: fcnt increments.
- speed is sampled at each frame_start. A reduced speed takes effect immediately because the compare is ≥.

Step arithmetic (10-bit intermediate, no lost carries):
- dir=0: v_offset ← v_offset+STEP, minus IMG_H if the sum ≥ IMG_H.
- dir=1: v_offset ← v_offset-STEP, plus IMG_H if the result is negative.
- The result is always in 0..IMG_H-1.

Direction:
- dir_pulse toggles dir in any state.
- A step in the same cycle as dir_pulse uses the pre-toggle dir.

Simultaneous events:
- btn_pulse with frame_start, in RUN: go to PAUSE, no step, fcnt unchanged.
- btn_pulse with frame_start, in PAUSE or IDLE: go to RUN, no step, fcnt = 0.
- home_pulse with frame_start, in any state other than HOME: go to HOME, v_offset unchanged. The offset clears on the next frame_start.
- v_offset changes only on a frame_start cycle.

## Timing
- Reset values: state=IDLE, v_offset=0, dir=0, running=0, fcnt=0.
- Reset asserted mid-operation forces these values immediately (asynchronous).
- v_offset updates on the clk edge that samples frame_start, so it is visible one cycle after the pulse and well inside vertical blanking.
- state, running and dir update one cycle after their causing pulse.
- With speed=s in steady RUN, steps occur every 2^s frame_start pulses. The first step follows 2^s frames after entering RUN.
- Back-to-back frame_start pulses on consecutive cycles must be handled; each pulse counts as one frame.

## Structure
- Shared package scroll_pkg holds:
  - the state encoding constants (IDLE, RUN, PAUSE, HOME);
  - the speed→period mapping;
  - the offset width localparam (9).
- One natural sub-module, frame_tick_div:
  - contains fcnt and the ≥ compare;
  - inputs: clk, rst, clear, frame_start, speed;
  - output: step_tick.
- The FSM and the modular offset register stay in scroll_ctrl.

## Test plan
- Reset, then btn_pulse, speed=0, STEP=1, 5 frame_starts → v_offset reads 1, 2, 3, 4, 5, each one cycle after its frame_start; running=1.
- v_offset=239 with dir=0, one step → 0. v_offset=0 with dir=1, one step → 239. Repeat with STEP=7 from 236 → 3.
- speed=2 in RUN → steps only on the 4th, 8th and 12th frame_start. Switching speed to 0 while fcnt=2 → step on the next frame_start.
- btn_pulse coincident with frame_start in RUN at v_offset=10 → PAUSE, v_offset stays 10. Further frame_starts cause no change.
- home_pulse and btn_pulse in the same cycle at v_offset=50 → HOME, v_offset stays 50 until the next frame_start, then 0 and IDLE.
- Async rst asserted between clk edges during RUN at v_offset=120 → v_offset=0, state=IDLE, dir=0, without waiting for a clk edge.
